y86_mem_arbiter: RTL and testbench
==================================

Name: y86_mem_arbiter

Overview:
- Shares the single memory port of the y86 sequential core between the core and a burst DMA/loader requester.
- The core cannot stall, so it has absolute priority and passes straight through to memory.
- The DMA engine uses only cycles where the core drives neither bus_RE nor bus_WE.
- Used for program loading, memory dump and test-data injection while the core runs.

Parameters:
- ADDR_STEP, 4, address increment per DMA word.
- LEN_W, 16, width of the burst length/remaining counter.
- MAX_WAIT, 16, consecutive ungranted BURST cycles before starvation is flagged.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low.
- core_A  input  32  core bus address.
- core_RE  input  1  core read enable.
- core_WE  input  1  core write enable.
- core_wdata  input  32  core write data.
- core_rdata  output  32  read data to the core; equals mem_rdata, combinational.
- dma_start  input  1  start-burst pulse, sampled in IDLE only.
- dma_write  input  1  burst direction (1 = write to memory), captured at start.
- dma_addr  input  32  burst start address, captured at start.
- dma_len  input  LEN_W  burst length in words, captured at start.
- dma_wdata  input  32  write data for the current word.
- dma_wready  output  1  dma_wdata consumed this cycle; requester advances to the next word.
- dma_rdata  output  32  registered read data.
- dma_rvalid  output  1  dma_rdata valid, one-cycle pulse per word.
- dma_busy  output  1  state is BURST.
- dma_done  output  1  one-cycle pulse at end of burst.
- dma_starve  output  1  sticky starvation flag.
- mem_A  output  32  memory address.
- mem_RE  output  1  memory read enable.
- mem_WE  output  1  memory write enable.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data, combinational, same cycle.

Behaviour:
- States: IDLE, BURST, DONE. rst low forces IDLE asynchronously.
- Reset values: all registered outputs 0; addr/remaining/wait counters 0; dma_starve 0.
- core_act = core_RE | core_WE. If core_act, mem_* = core_* unchanged, combinationally, in every state. RE and WE both high is passed through as-is.
- grant = (state==BURST) & !core_act.
- When grant:
  - mem_A = cur_addr.
  - mem_RE = !wr_q; mem_WE = wr_q.
  - mem_wdata = dma_wdata.
  - dma_wready = wr_q, combinational.
- When neither core_act nor grant, mem_A, mem_RE, mem_WE and mem_wdata are all 0.
- Read grant: dma_rdata <= mem_rdata and dma_rvalid = 1 in the next cycle. Latency is exactly 1 cycle after the grant cycle. dma_rvalid is 0 in all other cycles.
- Each grant:
  - cur_addr += ADDR_STEP, wrapping mod 2^32.
  - remaining -= 1.
  - wait counter clears.
- IDLE, on dma_start:
  - Capture dma_addr, dma_write and dma_len; clear dma_starve.
  - If dma_len==0, go to DONE; otherwise go to BURST.
- IDLE, dma_start with dma_busy=1 cannot occur; dma_start is ignored in BURST and DONE.
- BURST:
  - A grant with remaining==1 goes to DONE the next cycle.
  - Each cycle without a grant increments the wait counter, saturating at MAX_WAIT.
  - Reaching MAX_WAIT sets dma_starve, which stays set until the next accepted dma_start.
  - The burst continues regardless of starvation.
- DONE: dma_done=1 for exactly one cycle, then IDLE. For a read burst, the final dma_rvalid coincides with dma_done.
- dma_busy = (state==BURST).
- Reset asserted mid-burst: the burst is abandoned, no dma_done is issued, and mem_* go to 0 unless the core is active. core_rdata is unaffected.

Test Plan:
- Core read at A=0x10 during DMA IDLE -> mem_A=0x10, mem_RE=1, core_rdata==mem_rdata same cycle; DMA outputs stay 0.
- DMA write, addr 0x100, len 3, core idle -> writes at 0x100/0x104/0x108 on three consecutive cycles with dma_wready=1 each; dma_done the cycle after the third write.
- DMA read, len 4, core reading on alternate cycles -> core always served; DMA accesses only core-idle cycles; dma_rvalid 1 cycle after each grant; 4 pulses total; done after the last word.
- Core active continuously for 20 cycles during BURST -> dma_starve rises after 16 ungranted cycles and stays set after the burst completes; it clears on the next dma_start.
- dma_len=0 start -> no memory access, dma_done pulse 1 cycle later; addr 0xFFFFFFFC with len 2 -> second access at 0x00000000.
- rst low mid-burst (after 2 of 5 words) -> immediate IDLE, dma_busy=0, no dma_done; a new start after reset runs its full length.

Source files
------------

// File: rtl/y86_mem_arbiter.sv
// Memory-port arbiter for the y86 sequential core: the core always wins, and a
// burst DMA/loader engine fills in the cycles where the core leaves the bus idle.
module y86_mem_arbiter #(
  parameter int ADDR_STEP = 4,
  parameter int LEN_W     = 16,
  parameter int MAX_WAIT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      core_A,
  input  logic             core_RE,
  input  logic             core_WE,
  input  logic [31:0]      core_wdata,
  output logic [31:0]      core_rdata,
  input  logic             dma_start,
  input  logic             dma_write,
  input  logic [31:0]      dma_addr,
  input  logic [LEN_W-1:0] dma_len,
  input  logic [31:0]      dma_wdata,
  output logic             dma_wready,
  output logic [31:0]      dma_rdata,
  output logic             dma_rvalid,
  output logic             dma_busy,
  output logic             dma_done,
  output logic             dma_starve,
  output logic [31:0]      mem_A,
  output logic             mem_RE,
  output logic             mem_WE,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t            state;
  logic [31:0]       cur_addr;
  logic              wr_q;
  logic [LEN_W-1:0]  remaining;
  logic [WAIT_W-1:0] wait_cnt;
  logic              core_act;
  logic              grant;

  assign core_act   = core_RE | core_WE;
  assign grant      = (state == BURST) && !core_act;
  assign dma_wready = grant & wr_q;
  assign dma_busy   = (state == BURST);
  assign dma_done   = (state == DONE);
  assign core_rdata = mem_rdata;

  // The core cannot stall, so it is muxed onto the port ahead of any DMA grant.
  always_comb begin
    mem_A     = 32'd0;
    mem_RE    = 1'b0;
    mem_WE    = 1'b0;
    mem_wdata = 32'd0;
    if (core_act) begin
      mem_A     = core_A;
      mem_RE    = core_RE;
      mem_WE    = core_WE;
      mem_wdata = core_wdata;
    end else if (grant) begin
      mem_A     = cur_addr;
      mem_RE    = !wr_q;
      mem_WE    = wr_q;
      mem_wdata = dma_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cur_addr   <= 32'd0;
      wr_q       <= 1'b0;
      remaining  <= '0;
      wait_cnt   <= '0;
      dma_starve <= 1'b0;
      dma_rdata  <= 32'd0;
      dma_rvalid <= 1'b0;
    end else begin
      dma_rvalid <= 1'b0;
      if (grant && !wr_q) begin
        dma_rvalid <= 1'b1;
        dma_rdata  <= mem_rdata;
      end
      case (state)
        IDLE: begin
          if (dma_start) begin
            cur_addr   <= dma_addr;
            wr_q       <= dma_write;
            remaining  <= dma_len;
            wait_cnt   <= '0;
            dma_starve <= 1'b0;
            state      <= (dma_len == '0) ? DONE : BURST;
          end
        end
        BURST: begin
          if (grant) begin
            cur_addr  <= cur_addr + 32'(ADDR_STEP);
            remaining <= remaining - LEN_W'(1);
            wait_cnt  <= '0;
            if (remaining == LEN_W'(1))
              state <= DONE;
          end else begin
            // Starvation is only reported; the burst keeps waiting for a free cycle.
            if (wait_cnt != WAIT_W'(MAX_WAIT))
              wait_cnt <= wait_cnt + WAIT_W'(1);
            if (wait_cnt >= WAIT_W'(MAX_WAIT - 1))
              dma_starve <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Randomized and directed bench for y86_mem_arbiter, checked against a
// transaction-level model of the arbitration rules kept in this file.
module tb_y86_mem_arbiter;

  localparam int LEN_W     = 16;
  localparam int MAX_WAIT  = 16;
  localparam int ADDR_STEP = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      core_A;
  logic             core_RE;
  logic             core_WE;
  logic [31:0]      core_wdata;
  logic [31:0]      core_rdata;
  logic             dma_start;
  logic             dma_write;
  logic [31:0]      dma_addr;
  logic [LEN_W-1:0] dma_len;
  logic [31:0]      dma_wdata;
  logic             dma_wready;
  logic [31:0]      dma_rdata;
  logic             dma_rvalid;
  logic             dma_busy;
  logic             dma_done;
  logic             dma_starve;
  logic [31:0]      mem_A;
  logic             mem_RE;
  logic             mem_WE;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  y86_mem_arbiter #(.ADDR_STEP(ADDR_STEP), .LEN_W(LEN_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .core_A(core_A), .core_RE(core_RE), .core_WE(core_WE),
    .core_wdata(core_wdata), .core_rdata(core_rdata),
    .dma_start(dma_start), .dma_write(dma_write), .dma_addr(dma_addr),
    .dma_len(dma_len), .dma_wdata(dma_wdata), .dma_wready(dma_wready),
    .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_busy(dma_busy),
    .dma_done(dma_done), .dma_starve(dma_starve),
    .mem_A(mem_A), .mem_RE(mem_RE), .mem_WE(mem_WE),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]} + 32'h1357_9BDF;
  endfunction

  assign mem_rdata = mem_fn(mem_A);

  int total = 0;
  int bad   = 0;

  // Transaction-level picture of the DMA engine: burst in flight, words left, next address.
  bit          m_busy, m_done, m_wr, m_starve, m_rvalid;
  logic [31:0] m_addr, m_rdata;
  int          m_left, m_ungranted;
  int          done_seen, rvalid_seen;
  logic [31:0] dma_log[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_busy = 0; m_done = 0; m_wr = 0; m_starve = 0; m_rvalid = 0;
    m_addr = 0; m_rdata = 0; m_left = 0; m_ungranted = 0;
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance the model at the rising edge.
  task automatic applyStimulus(input bit re, input bit we, input logic [31:0] a,
                               input bit start, input bit wr, input logic [31:0] saddr,
                               input int len);
    bit          act, grant, prev_done;
    logic [31:0] e_a, e_wd;
    bit          e_re, e_we;
    core_RE = re; core_WE = we; core_A = a; core_wdata = $urandom;
    dma_start = start; dma_write = wr; dma_addr = saddr; dma_len = len[LEN_W-1:0];
    dma_wdata = $urandom;
    @(negedge clk);
    act   = re | we;
    grant = m_busy && !act;
    e_a = 0; e_re = 0; e_we = 0; e_wd = 0;
    if (act) begin
      e_a = a; e_re = re; e_we = we; e_wd = core_wdata;
    end else if (grant) begin
      e_a = m_addr; e_re = !m_wr; e_we = m_wr; e_wd = dma_wdata;
    end
    checkOutput("mem_A", mem_A, e_a);
    checkOutput("mem_RE", 32'(mem_RE), 32'(e_re));
    checkOutput("mem_WE", 32'(mem_WE), 32'(e_we));
    checkOutput("mem_wdata", mem_wdata, e_wd);
    checkOutput("core_rdata", core_rdata, mem_fn(e_a));
    checkOutput("dma_wready", 32'(dma_wready), 32'(grant && m_wr));
    checkOutput("dma_busy", 32'(dma_busy), 32'(m_busy));
    checkOutput("dma_done", 32'(dma_done), 32'(m_done));
    checkOutput("dma_starve", 32'(dma_starve), 32'(m_starve));
    checkOutput("dma_rvalid", 32'(dma_rvalid), 32'(m_rvalid));
    if (m_rvalid) checkOutput("dma_rdata", dma_rdata, m_rdata);
    if (!act && (mem_RE || mem_WE)) dma_log.push_back(mem_A);
    if (dma_done) done_seen++;
    if (dma_rvalid) rvalid_seen++;
    @(posedge clk);
    prev_done = m_done;
    m_done    = 0;
    m_rvalid  = grant && !m_wr;
    if (m_rvalid) m_rdata = mem_fn(m_addr);
    if (m_busy) begin
      if (grant) begin
        m_addr = m_addr + ADDR_STEP;
        m_left--;
        m_ungranted = 0;
        if (m_left == 0) begin
          m_busy = 0;
          m_done = 1;
        end
      end else begin
        if (m_ungranted < MAX_WAIT) m_ungranted++;
        if (m_ungranted == MAX_WAIT) m_starve = 1;
      end
    end else if (!prev_done && start) begin
      m_addr = saddr; m_wr = wr; m_left = len; m_starve = 0; m_ungranted = 0;
      if (len == 0) m_done = 1;
      else m_busy = 1;
    end
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 32'd0, 0, 0, 32'd0, 0);
  endtask

  task automatic doReset();
    core_RE = 0; core_WE = 0; core_A = 0; core_wdata = 0;
    dma_start = 0; dma_write = 0; dma_addr = 0; dma_len = 0; dma_wdata = 0;
    rst = 1'b0;
    modelReset();
    #2;
    checkOutput("rst_busy", 32'(dma_busy), 32'd0);
    checkOutput("rst_done", 32'(dma_done), 32'd0);
    checkOutput("rst_rvalid", 32'(dma_rvalid), 32'd0);
    checkOutput("rst_starve", 32'(dma_starve), 32'd0);
    checkOutput("rst_memA", mem_A, 32'd0);
    checkOutput("rst_memRE", 32'(mem_RE), 32'd0);
    checkOutput("rst_memWE", 32'(mem_WE), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0, r0;
    int mode;
    rst = 1'b0;
    #1;
    doReset();

    // Core read while DMA idles.
    applyStimulus(1, 0, 32'h10, 0, 0, 32'd0, 0);

    // Write burst of 3 with an idle core.
    dma_log.delete();
    d0 = done_seen;
    applyStimulus(0, 0, 32'd0, 1, 1, 32'h100, 3);
    repeat (5) idleCycle();
    checkOutput("wr_count", 32'(dma_log.size()), 32'd3);
    if (dma_log.size() == 3) begin
      checkOutput("wr_addr0", dma_log[0], 32'h100);
      checkOutput("wr_addr1", dma_log[1], 32'h104);
      checkOutput("wr_addr2", dma_log[2], 32'h108);
    end
    checkOutput("wr_done_cnt", 32'(done_seen - d0), 32'd1);

    // Read burst of 4 with the core reading every other cycle.
    dma_log.delete();
    d0 = done_seen; r0 = rvalid_seen;
    applyStimulus(0, 0, 32'd0, 1, 0, 32'h2000, 4);
    for (int i = 0; i < 12; i++)
      applyStimulus(i % 2 == 0, 0, 32'h40 + 32'(i * 4), 0, 0, 32'd0, 0);
    checkOutput("rd_count", 32'(dma_log.size()), 32'd4);
    if (dma_log.size() == 4) checkOutput("rd_addr3", dma_log[3], 32'h200C);
    checkOutput("rd_rvalid_cnt", 32'(rvalid_seen - r0), 32'd4);
    checkOutput("rd_done_cnt", 32'(done_seen - d0), 32'd1);

    // Starvation: core busy for 20 cycles during a burst.
    applyStimulus(0, 0, 32'd0, 1, 0, 32'h3000, 2);
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, 32'h80, 0, 0, 32'd0, 0);
    checkOutput("starve_set", 32'(dma_starve), 32'd1);
    repeat (5) idleCycle();
    checkOutput("starve_sticky", 32'(dma_starve), 32'd1);
    applyStimulus(0, 0, 32'd0, 1, 1, 32'h3100, 1);
    checkOutput("starve_clear", 32'(dma_starve), 32'd0);
    repeat (3) idleCycle();

    // Zero-length burst, then an address-wrapping burst.
    dma_log.delete();
    d0 = done_seen;
    applyStimulus(0, 0, 32'd0, 1, 0, 32'h500, 0);
    checkOutput("len0_done", 32'(dma_done), 32'd1);
    repeat (2) idleCycle();
    checkOutput("len0_noaccess", 32'(dma_log.size()), 32'd0);
    applyStimulus(0, 0, 32'd0, 1, 0, 32'hFFFF_FFFC, 2);
    repeat (4) idleCycle();
    checkOutput("wrap_count", 32'(dma_log.size()), 32'd2);
    if (dma_log.size() == 2) checkOutput("wrap_addr1", dma_log[1], 32'h0);
    checkOutput("wrap_done_cnt", 32'(done_seen - d0), 32'd2);

    // Reset after 2 of 5 words, then a fresh burst runs to completion.
    applyStimulus(0, 0, 32'd0, 1, 1, 32'h600, 5);
    repeat (2) idleCycle();
    d0 = done_seen;
    doReset();
    dma_log.delete();
    applyStimulus(0, 0, 32'd0, 1, 1, 32'h700, 3);
    repeat (5) idleCycle();
    checkOutput("post_rst_count", 32'(dma_log.size()), 32'd3);
    checkOutput("post_rst_done", 32'(done_seen - d0), 32'd1);

    // Randomized traffic; windows of heavy core load provoke starvation.
    mode = 0;
    for (int i = 0; i < 600; i++) begin
      bit re, we, st;
      logic [31:0] sa;
      if (i % 40 == 0) mode = $urandom_range(0, 2);
      re = ($urandom_range(0, 99) < (mode == 2 ? 95 : 35));
      we = !re && ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 99) < 3) begin
        re = 1; we = 1;
      end
      st = ($urandom_range(0, 3) == 0);
      sa = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4))
                                        : {$urandom, 2'b00};
      applyStimulus(re, we, $urandom, st, 1'($urandom_range(0, 1)), sa, $urandom_range(0, 6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
